// File: rtl/pool_window_buffer.sv
// Streaming KxK window generator for the max-pool path: raster pixels in, one window per
// qualifying pixel out, valid/ready on both sides.

// Per-column history of the previous K-1 rows; entry 0 is the oldest row.
module pool_wb_col #(
    parameter int BITWIDTH = 8,
    parameter int K        = 2
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         we_i,
    input  logic [BITWIDTH-1:0]          din_i,
    output logic [K-2:0][BITWIDTH-1:0]   hist_o
);
    logic [K-2:0][BITWIDTH-1:0] hist_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= '0;
        end else if (we_i) begin
            for (int j = 0; j < K-2; j++) hist_q[j] <= hist_q[j+1];
            hist_q[K-2] <= din_i;
        end
    end

    assign hist_o = hist_q;
endmodule

module pool_window_buffer #(
    parameter int BITWIDTH = 8,
    parameter int K        = 2,
    parameter int MAX_COLS = 32,
    parameter int COL_W    = $clog2(MAX_COLS+1)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clear,
    input  logic [COL_W-1:0]          cfg_cols,
    input  logic                      cfg_stride_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BITWIDTH-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [K*K*BITWIDTH-1:0]   out_window
);
    localparam int KW = $clog2(K);
    typedef logic [K-1:0][K-1:0][BITWIDTH-1:0] win_t;

    logic [COL_W-1:0] col_q, col_d, cols_eff;
    logic [KW-1:0]    row_seen_q, row_seen_d, row_ph_q, row_ph_d, col_ph_q, col_ph_d;
    win_t             win_q, win_d, out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             acc, last_col, emit;

    logic [MAX_COLS-1:0][K-2:0][BITWIDTH-1:0] hist;
    logic [K-2:0][BITWIDTH-1:0]               hist_sel;

    assign cols_eff = (cfg_cols > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : cfg_cols;
    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign acc      = in_valid && in_ready;
    assign last_col = (cols_eff == '0) || (col_q >= cols_eff - COL_W'(1));
    assign emit     = acc && (row_seen_q == KW'(K-1)) && (col_q >= COL_W'(K-1)) &&
                      (!cfg_stride_en || ((col_ph_q == KW'(K-1)) && (row_ph_q == KW'(K-1))));

    for (genvar i = 0; i < MAX_COLS; i++) begin : g_col
        pool_wb_col #(.BITWIDTH(BITWIDTH), .K(K)) u_col (
            .clk_i  (clk),
            .rstn_i (rstn),
            .we_i   (acc && (col_q == COL_W'(i))),
            .din_i  (in_data),
            .hist_o (hist[i])
        );
    end

    always_comb begin
        hist_sel = '0;
        for (int i = 0; i < MAX_COLS; i++)
            if (col_q == COL_W'(i)) hist_sel = hist[i];
    end

    // Window shifts left one column per accepted pixel; the new right column is the
    // column history (read before its own update) topped by the incoming pixel.
    always_comb begin
        win_d = win_q;
        if (acc) begin
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K-1; c++) win_d[r][c] = win_q[r][c+1];
            for (int r = 0; r < K-1; r++) win_d[r][K-1] = hist_sel[r];
            win_d[K-1][K-1] = in_data;
        end
    end

    always_comb begin
        col_d       = col_q;
        row_seen_d  = row_seen_q;
        row_ph_d    = row_ph_q;
        col_ph_d    = col_ph_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (clear) begin
            col_d       = '0;
            row_seen_d  = '0;
            row_ph_d    = '0;
            col_ph_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            if (acc) begin
                if (last_col) begin
                    col_d    = '0;
                    col_ph_d = '0;
                    if (row_seen_q != KW'(K-1)) row_seen_d = row_seen_q + KW'(1);
                    row_ph_d = (row_ph_q == KW'(K-1)) ? '0 : row_ph_q + KW'(1);
                end else begin
                    col_d    = col_q + COL_W'(1);
                    col_ph_d = (col_ph_q == KW'(K-1)) ? '0 : col_ph_q + KW'(1);
                end
            end
            if (emit) begin
                out_valid_d = 1'b1;
                out_d       = win_d;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_q       <= '0;
            row_seen_q  <= '0;
            row_ph_q    <= '0;
            col_ph_q    <= '0;
            win_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_seen_q  <= row_seen_d;
            row_ph_q    <= row_ph_d;
            col_ph_q    <= col_ph_d;
            win_q       <= win_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_q;
endmodule

// File: tb/tb_pool_window_buffer.sv
// Scoreboard bench for pool_window_buffer: K=2 (MAX_COLS=4) and K=3 (MAX_COLS=8) instances.
module tb_pool_window_buffer;
    logic        clk = 1'b0, rstn = 1'b0, clear = 1'b0, out_ready = 1'b1;
    logic        in_valid = 1'b0, stride = 1'b0, dsel = 1'b0;
    logic [7:0]  in_data = '0;
    logic [2:0]  cfg2 = 3'd4;
    logic [3:0]  cfg3 = 4'd6;
    logic        ir2, ov2, ir3, ov3;
    logic [31:0] ow2;
    logic [71:0] ow3;
    logic        ir_s, ov_s;
    logic [71:0] ow_s;

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pool_window_buffer #(.BITWIDTH(8), .K(2), .MAX_COLS(4)) u_k2 (
        .clk(clk), .rstn(rstn), .clear(clear), .cfg_cols(cfg2), .cfg_stride_en(stride),
        .in_valid(in_valid && !dsel), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_window(ow2));

    pool_window_buffer #(.BITWIDTH(8), .K(3), .MAX_COLS(8)) u_k3 (
        .clk(clk), .rstn(rstn), .clear(clear), .cfg_cols(cfg3), .cfg_stride_en(stride),
        .in_valid(in_valid && dsel), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_window(ow3));

    assign ir_s = dsel ? ir3 : ir2;
    assign ov_s = dsel ? ov3 : ov2;
    assign ow_s = dsel ? ow3 : {40'b0, ow2};

    typedef struct { logic [71:0] w; int cyc; } exp_t;
    exp_t q[$];

    int          chk = 0, err = 0;
    int          pix, tot, g_cols, g_k, g_str, nwin, stall;
    bit          lat_chk, stall_req, have_hold;
    logic [71:0] first_w, last_w, hold;
    string       cur;

    // One cycle: drive, sample at negedge (monitor, stall checks, model on accept), advance.
    task automatic tick();
        exp_t e;
        int   r0, c0;
        in_valid  = (pix < tot);
        in_data   = 8'(pix);
        out_ready = (stall == 0);
        @(negedge clk);
        if (stall > 0) begin
            chk++;
            if (ir_s !== 1'b0 || ov_s !== 1'b1)
                $display("FAIL %s stall_handshake in_ready=%b out_valid=%b want 0/1", cur, ir_s, ov_s);
            if (ir_s !== 1'b0 || ov_s !== 1'b1) err++;
            if (have_hold) begin
                chk++;
                if (ow_s !== hold) begin
                    err++;
                    $display("FAIL %s stall_window got=%h want=%h", cur, ow_s, hold);
                end
            end
            hold = ow_s; have_hold = 1'b1;
            stall--;
        end
        if (ov_s && out_ready) begin
            chk++;
            if (q.size() == 0) begin
                err++;
                $display("FAIL %s spurious_window got=%h want=none", cur, ow_s);
            end else begin
                e = q.pop_front();
                if (ow_s !== e.w) begin
                    err++;
                    $display("FAIL %s window got=%h want=%h", cur, ow_s, e.w);
                end
                if (lat_chk) begin
                    chk++;
                    if (cyc != e.cyc) begin
                        err++;
                        $display("FAIL %s latency got_cycle=%0d want_cycle=%0d", cur, cyc, e.cyc);
                    end
                end
                if (nwin == 0) first_w = ow_s;
                last_w = ow_s;
                nwin++;
                if (stall_req && nwin == 1) begin stall = 5; stall_req = 1'b0; end
            end
        end
        if (in_valid && ir_s) begin
            r0 = pix / g_cols;
            c0 = pix % g_cols;
            if (r0 >= g_k-1 && c0 >= g_k-1 &&
                (g_str == 0 || (r0 % g_k == g_k-1 && c0 % g_k == g_k-1))) begin
                e.w = '0;
                for (int r = 0; r < g_k; r++)
                    for (int c = 0; c < g_k; c++)
                        e.w[(r*g_k+c)*8 +: 8] = 8'((r0-g_k+1+r)*g_cols + c0-g_k+1+c);
                e.cyc = cyc + 1;
                q.push_back(e);
            end
            pix++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_frame(input int ds, input int cfg, input int cols, input int rows,
                             input int str, input int npix, input bit drain, input bit do_clr,
                             input bit stl, input int exp_n, input logic [71:0] exp_first,
                             input logic [71:0] exp_last, input string nm);
        int guard = 0;
        cur = nm; dsel = ds[0]; g_cols = cols; g_k = ds ? 3 : 2; g_str = str;
        if (do_clr) begin
            clear = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            cfg2 = 3'(cfg); cfg3 = 4'(cfg); stride = str[0];
            @(posedge clk); #1;
            clear = 1'b0;
        end
        q.delete();
        pix = 0; tot = (npix >= 0) ? npix : rows*cols;
        nwin = 0; stall = 0; stall_req = stl; have_hold = 1'b0; lat_chk = !stl;
        while ((pix < tot || (drain && q.size() > 0)) && guard < 2000) begin
            tick(); guard++;
        end
        if (guard >= 2000) begin
            chk++; err++;
            $display("FAIL %s timeout pix=%0d want=%0d pending=%0d", nm, pix, tot, q.size());
        end
        if (drain) begin
            repeat (4) tick();
            chk++;
            if (nwin != exp_n) begin
                err++;
                $display("FAIL %s window_count got=%0d want=%0d", nm, nwin, exp_n);
            end
            if (exp_n > 0) begin
                chk++;
                if (first_w !== exp_first) begin
                    err++;
                    $display("FAIL %s first_window got=%h want=%h", nm, first_w, exp_first);
                end
                chk++;
                if (last_w !== exp_last) begin
                    err++;
                    $display("FAIL %s last_window got=%h want=%h", nm, last_w, exp_last);
                end
            end
        end
    endtask

    task automatic test_reset();
        #2;
        chk++; if (ov2 !== 1'b0) begin err++; $display("FAIL reset_valid_k2 got=%b want=0", ov2); end
        chk++; if (ow2 !== '0)   begin err++; $display("FAIL reset_window_k2 got=%h want=0", ow2); end
        chk++; if (ir2 !== 1'b1) begin err++; $display("FAIL reset_ready_k2 got=%b want=1", ir2); end
        chk++; if (ov3 !== 1'b0 || ow3 !== '0) begin
            err++; $display("FAIL reset_k3 valid=%b window=%h want 0/0", ov3, ow3);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stride_k2();
        run_frame(0, 4, 4, 4, 1, -1, 1, 1, 0, 4, 72'h05040100, 72'h0f0e0b0a, "stride_k2");
    endtask

    task automatic test_every_k2();
        run_frame(0, 4, 4, 4, 0, -1, 1, 1, 0, 9, 72'h05040100, 72'h0f0e0b0a, "every_k2");
    endtask

    task automatic test_back_to_back_stall();
        run_frame(0, 4, 4, 4, 0, -1, 1, 1, 1, 9, 72'h05040100, 72'h0f0e0b0a, "backpressure");
    endtask

    task automatic test_short_rows();
        run_frame(0, 3, 3, 4, 1, -1, 1, 1, 0, 2, 72'h04030100, 72'h0a090706, "cols3");
        run_frame(0, 1, 1, 4, 1, -1, 1, 1, 0, 0, '0, '0, "cols1");
        run_frame(0, 7, 4, 4, 1, -1, 1, 1, 0, 4, 72'h05040100, 72'h0f0e0b0a, "cols_clamp");
    endtask

    task automatic test_clear();
        run_frame(0, 4, 4, 4, 1, 6, 0, 1, 0, 0, '0, '0, "clear_pre");
        out_ready = 1'b0; clear = 1'b1; in_valid = 1'b1; in_data = 8'd99;
        @(negedge clk);
        chk++; if (ir2 !== 1'b0) begin err++; $display("FAIL clear_in_ready got=%b want=0", ir2); end
        chk++; if (ov2 !== 1'b1) begin err++; $display("FAIL clear_pending_valid got=%b want=1", ov2); end
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk++; if (ov2 !== 1'b0) begin err++; $display("FAIL clear_valid got=%b want=0", ov2); end
        chk++; if (ow2 !== 32'h05040100) begin
            err++; $display("FAIL clear_window_hold got=%h want=05040100", ow2);
        end
        run_frame(0, 4, 4, 4, 1, -1, 1, 1, 0, 4, 72'h05040100, 72'h0f0e0b0a, "after_clear");
    endtask

    task automatic test_rst_mid();
        run_frame(0, 4, 4, 4, 1, 6, 0, 1, 0, 0, '0, '0, "rst_pre");
        rstn = 1'b0; in_valid = 1'b0;
        #1;
        chk++; if (ov2 !== 1'b0) begin err++; $display("FAIL rst_mid_valid got=%b want=0", ov2); end
        chk++; if (ow2 !== '0)   begin err++; $display("FAIL rst_mid_window got=%h want=0", ow2); end
        chk++; if (ir2 !== 1'b1) begin err++; $display("FAIL rst_mid_ready got=%b want=1", ir2); end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 4, 4, 4, 1, -1, 1, 0, 0, 4, 72'h05040100, 72'h0f0e0b0a, "after_rst");
    endtask

    task automatic test_k3();
        run_frame(1, 6, 6, 6, 1, -1, 1, 1, 0, 4, 72'h0e0d0c080706020100,
                  72'h2322211d1c1b171615, "k3_stride");
    endtask

    initial begin
        test_reset();
        test_stride_k2();
        test_every_k2();
        test_back_to_back_stall();
        test_short_rows();
        test_clear();
        test_rst_mid();
        test_k3();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/pool_window_buffer.md
# pool_window_buffer

Parametrised streaming window generator for the max-pool datapath. It accepts one pixel per cycle in raster order over a frame with a runtime-programmable row length. It stores the previous K-1 rows and emits a complete K×K window for each qualifying pixel, either at every position (stride 1) or only at pooling-aligned positions (stride K). Valid/ready handshakes sit on both sides, between the feature-map source and the K×K max comparator.

## Interface
- BITWIDTH, 8, pixel width in bits
- K, 2, window height and width (K ≥ 2)
- MAX_COLS, 32, maximum supported row length (≥ K)
- COL_W, $clog2(MAX_COLS+1), width of cfg_cols
- clk  input  1  clock
- rstn  input  1  reset; asynchronous, active-low
- clear  input  1  synchronous frame restart
- cfg_cols  input  COL_W  active row length in pixels
- cfg_stride_en  input  1  1: emit only stride-K aligned windows; 0: emit every window
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  BITWIDTH  pixel, raster order
- out_valid  output  1  out_window is valid
- out_ready  input  1  consumer accepts out_window
- out_window  output  K*K*BITWIDTH  flattened window; element (r,c) at bits [(r*K+c)*BITWIDTH +: BITWIDTH]; r=0 is the oldest row, c=0 the leftmost column

## Operation
- Accept occurs when in_valid && in_ready.
- in_ready = !clear && (!out_valid || out_ready). This is combinational, with no bubble under continuous flow.
- Counters:
  - col runs 0..cfg_cols-1 and wraps to 0, incrementing row_seen.
  - row_seen saturates at K-1.
  - row_phase counts mod K and increments on each wrap.
  - col_phase counts mod K and resets to 0 at each wrap.
- Storage: K-1 row histories of up to MAX_COLS pixels each, plus the current-row tail of K pixels. The implementation of this storage is free, but it must be cycle-exact to the behaviour below.
- Window for an accepted pixel at (row R, col C) consists of pixels at rows R-K+1..R and cols C-K+1..C.
- Emit condition on accept:
  - Base condition: row_seen == K-1 and col ≥ K-1.
  - With cfg_stride_en=1, additionally col_phase == K-1 and row_phase == K-1.
- Emit action: on the next edge, out_window is loaded and out_valid is set.
  - out_valid stays set and out_window stays stable until out_ready.
  - On out_ready without a new emit, out_valid clears.
  - On out_ready with a new emit in the same cycle, out_window reloads and out_valid stays 1.
- Config rules:
  - cfg_cols and cfg_stride_en may change only while clear is high. Behaviour otherwise is undefined.
  - cfg_cols < K: pixels are accepted and counted, but no window is ever emitted.
  - cfg_cols > MAX_COLS: treated as MAX_COLS.
- clear:
  - Zeroes all counters and out_valid in the same edge.
  - Overrides any accept or emit in that cycle.
  - Stored pixel contents are don't-care after clear.
  - out_window holds its value after clear.
- Frame boundaries are implicit. Software pulses clear between frames.

## Timing
- Reset values: out_valid=0, out_window=0, all counters=0, stored pixels=0. in_ready=1 after reset when clear=0.
- Latency: 1 cycle from the accepting edge to out_valid/out_window.
- Throughput: 1 pixel/cycle, and 1 window/cycle in stride-1 mode, with out_ready held high.
- Backpressure: a stalled output (out_valid && !out_ready) forces in_ready=0. No pixels are dropped or duplicated.
- Reset mid-operation: state returns to reset values immediately (asynchronous). The first pixel after reset is row 0, col 0.
- Wrap: a pixel at col=cfg_cols-1 both completes the row, possibly emitting a window, and advances the row counters in the same edge.

## Test plan
- K=2, cols=4, stride_en=1; stream a 4×4 frame with value=row*4+col and out_ready=1. Require exactly 4 windows, in order:
  - {0,1,4,5}
  - {2,3,6,7}
  - {8,9,12,13}
  - {10,11,14,15}
  Each window appears one cycle after accepting pixels 5, 7, 13 and 15 respectively.
- Same frame with stride_en=0: require 9 windows, first {0,1,4,5}, last {10,11,14,15}, and none emitted during row 0 or at col 0.
- Backpressure: hold out_ready=0 for 5 cycles after the first window. Require in_ready=0 and a stable out_window for those cycles. Release out_ready; the following windows must match the ideal sequence exactly.
- K=2, cols=3, stride_en=1, 4×3 frame: require windows only at col 1, giving {0,1,3,4} and {6,7,9,10}. K=2, cols=1: require no windows at all.
- Mid-frame clear after 6 pixels, then a fresh 4×4 frame:
  - In the clear cycle, in_ready=0 and no accept occurs.
  - out_valid=0 after the clear.
  - Outputs then match the first scenario.
  - Repeat with a rstn pulse in place of clear: out_window resets to 0 and behaviour afterwards is identical.
- K=3, cols=6, stride_en=1, 6×6 frame of value=row*6+col: require 4 windows, the first being {0,1,2,6,7,8,12,13,14}.
